// File: rtl/riscv_pkg.sv
// Shared fetch-side types for the core.
// Entry layout and FSM encoding used by fetch_unit and fetch_buf.
package riscv_pkg;

  localparam int unsigned XLEN_W = 32;

  localparam logic [XLEN_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FAULT = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN_W-1:0] pc;
    logic [XLEN_W-1:0] instr;
    logic              fault;
  } fetch_entry_t;

  localparam fetch_entry_t EMPTY_ENTRY = '{
    pc:    '0,
    instr: NOP_INSTR,
    fault: 1'b0
  };

endpackage

// File: rtl/fetch_buf.sv
// Small synchronous FIFO of fetch entries.
// Flush and reset both clear it; a pop frees a full slot the same cycle.
module fetch_buf
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd;
  logic [AW-1:0]  wr;
  logic [AW:0]    cnt;
  logic           do_pop;
  logic           do_push;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? EMPTY_ENTRY : mem[rd];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd  <= '0;
      wr  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wr <= wr + AW'(1);
      if (do_pop)  rd <= rd + AW'(1);
      cnt <= cnt + (AW+1)'(do_push)
                 - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) begin
      mem[wr] <= din;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch PC, legality check and fetch-buffer push control.
// A bad PC yields one fault entry, then fetch halts until redirect.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = 32'h0000_0000,
  parameter int               MEM_SIZE     = 256,
  parameter int               BUF_DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] Iaddress,
  input  logic [XLEN-1:0] Idata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            out_fault
);

  localparam logic [XLEN-1:0] LIMIT =
    XLEN'(MEM_SIZE) << 2;

  logic [XLEN-1:0] fpc;
  fetch_state_t    state;
  fetch_state_t    state_n;
  logic [XLEN-1:0] fpc_n;
  fetch_entry_t    head;
  fetch_entry_t    din;
  logic            full;
  logic            empty;
  logic            pop;
  logic            push;
  logic            can_push;
  logic            legal;

  assign Iaddress  = fpc;
  assign out_valid = ~empty;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign out_fault = head.fault;

  assign pop      = out_valid & out_ready;
  assign can_push = ~full | pop;
  assign legal    = (fpc[1:0] == 2'b00) && (fpc < LIMIT);

  always_comb begin
    state_n = state;
    fpc_n   = fpc;
    push    = 1'b0;
    din     = '{pc: fpc, instr: Idata, fault: 1'b0};
    if (redirect_valid) begin
      state_n = RUN;
      fpc_n   = redirect_pc;
    end else begin
      unique case (1'b1)
        (state == RUN): begin
          if (!legal) begin
            state_n = FAULT;
          end else if (can_push) begin
            push  = 1'b1;
            fpc_n = fpc + XLEN'(4);
          end
        end
        (state == FAULT): begin
          din.instr = NOP_INSTR;
          din.fault = 1'b1;
          if (can_push) begin
            push    = 1'b1;
            state_n = HALT;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc   <= RESET_VECTOR;
      state <= RUN;
    end else begin
      fpc   <= fpc_n;
      state <= state_n;
    end
  end

  fetch_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (din),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected decode stream per redirect.
// Random ready/redirect/reset plus directed latency and halt checks.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          MSZ = 256;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] Iaddress;
  logic [31:0] Idata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_fault;

  logic [31:0] imem [MSZ];
  exp_t        exp_q[$];
  int          passed = 0;
  int          total  = 0;

  always #5 clk = ~clk;

  assign Idata = imem[Iaddress[9:2]];

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .Iaddress       (Iaddress),
    .Idata          (Idata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_fault      (out_fault)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h",
                  nm, act, exp);
  endtask

  // Whole stream decode should see after a restart at t.
  function automatic void fill(input logic [31:0] t);
    logic [31:0] pc;
    exp_q.delete();
    pc = t;
    while (pc[1:0] == 2'b00 && pc < 32'(MSZ * 4)) begin
      exp_q.push_back('{pc, imem[pc[9:2]], 1'b0});
      pc = pc + 32'd4;
    end
    exp_q.push_back('{pc, NOP, 1'b1});
  endfunction

  always @(negedge clk) begin
    if (!rst && !redirect_valid) begin
      if (out_valid) begin
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            $display("FAIL extra_pop: got pc %h expected none",
                     out_pc);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pop_pc", out_pc, e.pc);
            chk("pop_instr", out_instr, e.instr);
            chk("pop_fault", 32'(out_fault), 32'(e.fault));
          end
        end
      end else begin
        chk("idle_instr", out_instr, NOP);
        chk("idle_pc", out_pc, 32'h0);
        chk("idle_fault", 32'(out_fault), 32'h0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] t);
    redirect_valid = 1'b1;
    redirect_pc    = t;
    fill(t);
    tick();
    redirect_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    case ($urandom_range(0, 4))
      0: t = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      1: t = 32'h3E0 + 32'($urandom_range(0, 7)) * 4;
      2: t = {22'h0, 8'($urandom), 2'($urandom_range(1, 3))};
      3: t = 32'h400 + 32'($urandom_range(0, 63)) * 4;
      default: t = 32'hFFFF_FFFC;
    endcase
    return t;
  endfunction

  initial begin
    for (int i = 0; i < MSZ; i++) imem[i] = 32'h0010_0093 + i;

    rst = 1'b1;
    repeat (2) tick();
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_iaddr", Iaddress, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_instr", out_instr, NOP);
    chk("rst_fault", 32'(out_fault), 32'h0);
    rst = 1'b0;
    out_ready = 1'b1;
    fill(32'h0);
    tick();
    chk("first_valid", 32'(out_valid), 32'h1);
    chk("first_pc", out_pc, 32'h0);

    repeat (20) tick();

    out_ready = 1'b0;
    repeat (5) tick();
    chk("bp_valid", 32'(out_valid), 32'h1);
    chk("bp_head", out_pc, exp_q[0].pc);
    chk("bp_iaddr", Iaddress, exp_q[2].pc);
    out_ready = 1'b1;
    repeat (4) tick();

    out_ready = 1'b0;
    repeat (3) tick();
    redirect(32'h40);
    chk("rd_flush", 32'(out_valid), 32'h0);
    tick();
    chk("rd_valid", 32'(out_valid), 32'h1);
    chk("rd_pc", out_pc, 32'h40);
    out_ready = 1'b1;
    repeat (4) tick();

    redirect(32'h42);
    repeat (8) tick();
    chk("mis_valid", 32'(out_valid), 32'h0);
    chk("mis_iaddr", Iaddress, 32'h42);
    chk("mis_drained", 32'(exp_q.size()), 32'h0);
    redirect(32'h10);
    repeat (4) tick();

    redirect(32'h3F0);
    repeat (10) tick();
    chk("end_iaddr", Iaddress, 32'h400);
    chk("end_valid", 32'(out_valid), 32'h0);
    chk("end_drained", 32'(exp_q.size()), 32'h0);

    redirect(32'h100);
    out_ready = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    fill(32'h0);
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_iaddr", Iaddress, 32'h0);
    out_ready = 1'b1;
    tick();
    chk("mid_rst_pc", out_pc, 32'h0);
    repeat (6) tick();

    for (int c = 0; c < 3000; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 249) == 0) begin
        rst = 1'b1;
        fill(32'h0);
        tick();
        rst = 1'b0;
      end else if ($urandom_range(0, 24) == 0) begin
        redirect(rand_target());
      end else begin
        tick();
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
